centroid_divider_sequencer: RTL

Sequential stage that computes new k-means centroid coordinates by dividing each accumulated per-cluster coordinate sum by that cluster's point count. It walks all centroid slots of the accumulator memory. For each slot it runs a shared bit-serial unsigned divider over the 7 coordinates. It then presents the 7 quotients (`result_cord_1..7`) with a valid/ready handshake to the integer-to-fixed-point concatenation stage directly downstream.

---
 rtl/centroid_divider_sequencer.sv | 293 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/centroid_divider_sequencer.sv
// centroid_divider_sequencer
// Walks every centroid slot of the accumulator memory and divides each of the
// 7 coordinate sums by the slot's point count. A single restoring bit-serial
// divider is shared by all coordinates. Each slot's 7 quotients are presented
// downstream with a valid/ready handshake.
// Optional feature macro: CENTROID_DIV_ROUND_EN
//   When defined, the divider rounds to nearest: count/2 is added to the dividend,
//   and the divider runs one extra iteration.
//   When undefined, the divider truncates.
module centroid_divider_sequencer #(
    parameter int accum_cord_width = 22,
    parameter int count_width      = 10,
    parameter int addrWidth        = 8,
    parameter int centroid_num     = 8,
    parameter int accum_width      = 7 * accum_cord_width
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    output logic                            rd_en,
    output logic [addrWidth-1:0]            rd_addr,
    input  logic [accum_width-1:0]          rd_data,
    input  logic [count_width-1:0]          rd_count,
    output logic [accum_cord_width-1:0]     result_cord_1,
    output logic [accum_cord_width-1:0]     result_cord_2,
    output logic [accum_cord_width-1:0]     result_cord_3,
    output logic [accum_cord_width-1:0]     result_cord_4,
    output logic [accum_cord_width-1:0]     result_cord_5,
    output logic [accum_cord_width-1:0]     result_cord_6,
    output logic [accum_cord_width-1:0]     result_cord_7,
    output logic [$clog2(centroid_num)-1:0] result_idx,
    output logic                            zero_count,
    output logic                            result_valid,
    input  logic                            result_ready,
    output logic                            busy,
    output logic                            done
);

    localparam int W       = accum_cord_width;
    localparam int COORD_N = 7;
`ifdef CENTROID_DIV_ROUND_EN
    localparam int DIV_N   = accum_cord_width + 1;
`else
    localparam int DIV_N   = accum_cord_width;
`endif
    localparam int REM_W   = count_width + 1;
    localparam int ITER_W  = $clog2(DIV_N);
    localparam int IDX_W   = $clog2(centroid_num);
    localparam int SUMS_W  = accum_width - W;

    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(DIV_N - 1);
    localparam logic [IDX_W-1:0]  LAST_SLOT = IDX_W'(centroid_num - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        DIV  = 3'd3,
        OUT  = 3'd4
    } state_t;

    // Builds the divider's dividend for one coordinate sum.
    // In the rounding build, count/2 is added at one extra bit of width.
    function automatic logic [DIV_N-1:0] make_dividend(
        input logic [W-1:0]           sum,
        input logic [count_width-1:0] cnt
    );
        logic [DIV_N-1:0] ext_sum;
        logic [DIV_N-1:0] ext_half;
        ext_sum  = DIV_N'(sum);
`ifdef CENTROID_DIV_ROUND_EN
        ext_half = DIV_N'(cnt >> 1'b1);
`else
        ext_half = DIV_N'(cnt & {count_width{1'b0}});
`endif
        return ext_sum + ext_half;
    endfunction

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       slot_q, slot_d;
    logic [2:0]             coord_q, coord_d;
    logic [ITER_W-1:0]      iter_q, iter_d;
    logic [REM_W-1:0]       rem_q, rem_d;
    logic [W-1:0]           quot_q, quot_d;
    logic [DIV_N-1:0]       dividend_q, dividend_d;
    logic [SUMS_W-1:0]      sums_q, sums_d;
    logic [count_width-1:0] count_q, count_d;
    logic [W-1:0]           res_q [COORD_N];
    logic [W-1:0]           res_d [COORD_N];
    logic                   rd_en_q, rd_en_d;
    logic [addrWidth-1:0]   rd_addr_q, rd_addr_d;
    logic [IDX_W-1:0]       result_idx_q, result_idx_d;
    logic                   zero_count_q, zero_count_d;
    logic                   result_valid_q, result_valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [REM_W-1:0]       rem_shift_s;
    logic                   sub_ok_s;
    logic [REM_W-1:0]       rem_next_s;
    logic [W-1:0]           quot_next_s;
    logic [IDX_W-1:0]       slot_inc_s;

    // One restoring-divider iteration: shift in the next dividend bit, then subtract if possible.
    always_comb begin
        rem_shift_s = REM_W'({rem_q, dividend_q[DIV_N-1]});
        sub_ok_s    = (rem_shift_s >= {1'b0, count_q});
        if (sub_ok_s) begin
            rem_next_s = rem_shift_s - {1'b0, count_q};
        end else begin
            rem_next_s = rem_shift_s;
        end
        quot_next_s = W'({quot_q, sub_ok_s});
        slot_inc_s  = slot_q + 1'b1;
    end

    // Next-state and datapath control for the slot walk and the shared divider.
    always_comb begin
        state_d        = state_q;
        slot_d         = slot_q;
        coord_d        = coord_q;
        iter_d         = iter_q;
        rem_d          = rem_q;
        quot_d         = quot_q;
        dividend_d     = dividend_q;
        sums_d         = sums_q;
        count_d        = count_q;
        res_d          = res_q;
        rd_en_d        = 1'b0;
        rd_addr_d      = rd_addr_q;
        result_idx_d   = result_idx_q;
        zero_count_d   = zero_count_q;
        result_valid_d = 1'b0;
        busy_d         = busy_q;
        done_d         = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = READ;
                    slot_d       = '0;
                    rd_en_d      = 1'b1;
                    rd_addr_d    = '0;
                    busy_d       = 1'b1;
                    zero_count_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end

            READ: begin
                state_d = WAIT;
            end

            WAIT: begin
                // Memory data is valid now; coordinate 1 goes straight into the divider.
                sums_d       = rd_data[accum_width-1:W];
                count_d      = rd_count;
                result_idx_d = slot_q;
                coord_d      = 3'd1;
                iter_d       = '0;
                rem_d        = '0;
                quot_d       = '0;
                dividend_d   = make_dividend(rd_data[W-1:0], rd_count);
                if (rd_count == {count_width{1'b0}}) begin
                    zero_count_d   = 1'b1;
                    for (int i = 0; i < COORD_N; i++) begin
                        res_d[i] = '0;
                    end
                    result_valid_d = 1'b1;
                    state_d        = OUT;
                end else begin
                    zero_count_d = 1'b0;
                    state_d      = DIV;
                end
            end

            DIV: begin
                rem_d      = rem_next_s;
                quot_d     = quot_next_s;
                dividend_d = {dividend_q[DIV_N-2:0], 1'b0};
                if (iter_q == LAST_ITER) begin
                    for (int i = 0; i < COORD_N; i++) begin
                        if (coord_q == 3'(i + 1)) begin
                            res_d[i] = quot_next_s;
                        end else begin
                            res_d[i] = res_q[i];
                        end
                    end
                    iter_d = '0;
                    rem_d  = '0;
                    quot_d = '0;
                    if (coord_q == 3'(COORD_N)) begin
                        result_valid_d = 1'b1;
                        state_d        = OUT;
                    end else begin
                        // The remaining sums are consumed from the bottom, one coordinate at a time.
                        coord_d    = coord_q + 3'd1;
                        dividend_d = make_dividend(sums_q[W-1:0], count_q);
                        sums_d     = sums_q >> W;
                    end
                end else begin
                    iter_d = iter_q + 1'b1;
                end
            end

            OUT: begin
                if (result_ready) begin
                    result_valid_d = 1'b0;
                    if (slot_q == LAST_SLOT) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d      = READ;
                        slot_d       = slot_inc_s;
                        rd_en_d      = 1'b1;
                        rd_addr_d    = addrWidth'(slot_inc_s);
                        zero_count_d = 1'b0;
                    end
                end else begin
                    result_valid_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; reset discards any partial run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            slot_q         <= '0;
            coord_q        <= 3'd0;
            iter_q         <= '0;
            rem_q          <= '0;
            quot_q         <= '0;
            dividend_q     <= '0;
            sums_q         <= '0;
            count_q        <= '0;
            for (int i = 0; i < COORD_N; i++) begin
                res_q[i] <= '0;
            end
            rd_en_q        <= 1'b0;
            rd_addr_q      <= '0;
            result_idx_q   <= '0;
            zero_count_q   <= 1'b0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            slot_q         <= slot_d;
            coord_q        <= coord_d;
            iter_q         <= iter_d;
            rem_q          <= rem_d;
            quot_q         <= quot_d;
            dividend_q     <= dividend_d;
            sums_q         <= sums_d;
            count_q        <= count_d;
            for (int i = 0; i < COORD_N; i++) begin
                res_q[i] <= res_d[i];
            end
            rd_en_q        <= rd_en_d;
            rd_addr_q      <= rd_addr_d;
            result_idx_q   <= result_idx_d;
            zero_count_q   <= zero_count_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign rd_en         = rd_en_q;
    assign rd_addr       = rd_addr_q;
    assign result_cord_1 = res_q[0];
    assign result_cord_2 = res_q[1];
    assign result_cord_3 = res_q[2];
    assign result_cord_4 = res_q[3];
    assign result_cord_5 = res_q[4];
    assign result_cord_6 = res_q[5];
    assign result_cord_7 = res_q[6];
    assign result_idx    = result_idx_q;
    assign zero_count    = zero_count_q;
    assign result_valid  = result_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule
